fetch_pc_unit: RTL and testbench

// - Fetch-stage PC logic for the 5-stage Y86-64 pipeline.
// - Selects the PC to fetch (f_pc) from three sources: the predicted PC, a

---
 rtl/fetch_pc_unit_if.sv | 34 +++
 rtl/fetch_pc_unit.sv | 66 ++++++
 tb/tb_fetch_pc_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_if.sv
// Fetch-PC bus interface.
// Groups the fetch-stage control/data signals that connect the PC unit to the
// rest of the pipeline.
//   master : pipeline side, drives stall/M/W/f fields, observes PC outputs
//   slave  : fetch_pc_unit side, consumes those fields, produces
//            F_predPC (registered), f_pc and f_predPC (combinational)
interface fetch_pc_unit_if #(
  parameter int ADDR_W = 64
);
  logic              F_stall;
  logic [3:0]        M_icode;
  logic              M_cnd;
  logic [ADDR_W-1:0] M_valA;
  logic [3:0]        W_icode;
  logic [ADDR_W-1:0] W_valM;
  logic [3:0]        f_icode;
  logic [ADDR_W-1:0] f_valC;
  logic [ADDR_W-1:0] f_valP;
  logic [ADDR_W-1:0] F_predPC;
  logic [ADDR_W-1:0] f_pc;
  logic [ADDR_W-1:0] f_predPC;

  modport master (
    output F_stall, M_icode, M_cnd, M_valA, W_icode, W_valM,
           f_icode, f_valC, f_valP,
    input  F_predPC, f_pc, f_predPC
  );

  modport slave (
    input  F_stall, M_icode, M_cnd, M_valA, W_icode, W_valM,
           f_icode, f_valC, f_valP,
    output F_predPC, f_pc, f_predPC
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC logic for the 5-stage Y86-64 pipeline.
// Ports:
//   clk    : single clock, all state updates on the rising edge
//   reset  : synchronous active-high, loads F_predPC with RESET_PC
//   bus    : fetch_pc_unit_if.slave
//            inputs  F_stall, M_icode/M_cnd/M_valA, W_icode/W_valM,
//                    f_icode/f_valC/f_valP
//            outputs F_predPC (F pipeline register), f_pc (PC to fetch),
//                    f_predPC (predicted next PC)
module fetch_pc_unit #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input logic            clk,
  input logic            reset,
  fetch_pc_unit_if.slave bus
);

  localparam logic [3:0] ICODE_JXX  = 4'h7;
  localparam logic [3:0] ICODE_CALL = 4'h8;
  localparam logic [3:0] ICODE_RET  = 4'h9;

  logic [ADDR_W-1:0] pred_pc_r;
  logic [ADDR_W-1:0] fetch_pc_s;
  logic [ADDR_W-1:0] next_pred_s;

  // PC select: a not-taken branch in M was mispredicted (we always predict
  // taken) and outranks a ret in W; otherwise use the registered prediction.
  always_comb begin
    fetch_pc_s = pred_pc_r;
    if ((bus.M_icode == ICODE_JXX) && (bus.M_cnd == 1'b0)) begin
      fetch_pc_s = bus.M_valA;
    end else if (bus.W_icode == ICODE_RET) begin
      fetch_pc_s = bus.W_valM;
    end else begin
      fetch_pc_s = pred_pc_r;
    end
  end

  // Next-PC prediction: jumps and calls go to valC; ret is left to the stall
  // logic and simply falls through to valP like every other instruction.
  always_comb begin
    next_pred_s = bus.f_valP;
    case (bus.f_icode)
      ICODE_JXX:  next_pred_s = bus.f_valC;
      ICODE_CALL: next_pred_s = bus.f_valC;
      default:    next_pred_s = bus.f_valP;
    endcase
  end

  // F pipeline register; reset has priority over stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      pred_pc_r <= RESET_PC;
    end else if (bus.F_stall) begin
      pred_pc_r <= pred_pc_r;
    end else begin
      pred_pc_r <= next_pred_s;
    end
  end

  assign bus.F_predPC = pred_pc_r;
  assign bus.f_pc     = fetch_pc_s;
  assign bus.f_predPC = next_pred_s;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;
  localparam int ADDR_W = 64;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;
  logic [ADDR_W-1:0] model_f;
  logic [ADDR_W-1:0] exp_pred;
  logic [ADDR_W-1:0] exp_pc;
  logic [ADDR_W-1:0] next_f;

  fetch_pc_unit_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_pc_unit #(.ADDR_W(ADDR_W), .RESET_PC(64'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [ADDR_W-1:0] obs,
                       input logic [ADDR_W-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rand_icode();
    // Bias towards the interesting codes 7/8/9.
    if ($urandom_range(0, 1) == 0) return 4'($urandom_range(7, 9));
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset = 1'b1;
    bus.F_stall = 1'b0;
    bus.M_icode = 4'h0; bus.M_cnd = 1'b0; bus.M_valA = 64'h0;
    bus.W_icode = 4'h0; bus.W_valM = 64'h0;
    bus.f_icode = 4'h0; bus.f_valC = 64'h0; bus.f_valP = 64'h0;

    // Reset
    tick();
    check("reset_F_predPC", bus.F_predPC, 64'h0);
    check("reset_f_pc", bus.f_pc, 64'h0);
    reset = 1'b0;
    bus.f_icode = 4'h6; bus.f_valP = 64'h2;
    #1;
    check("other_pred", bus.f_predPC, 64'h2);
    tick();
    check("first_update", bus.F_predPC, 64'h2);
    check("f_pc_follows_reg", bus.f_pc, 64'h2);

    // Prediction
    bus.f_icode = 4'h7; bus.f_valC = 64'h40; bus.f_valP = 64'h9;
    #1; check("pred_jxx", bus.f_predPC, 64'h40);
    bus.f_icode = 4'h8;
    #1; check("pred_call", bus.f_predPC, 64'h40);
    bus.f_icode = 4'h9;
    #1; check("pred_ret", bus.f_predPC, 64'h9);

    // Mispredict vs ret
    bus.M_icode = 4'h7; bus.M_cnd = 1'b0; bus.M_valA = 64'h13;
    bus.W_icode = 4'h9; bus.W_valM = 64'h80;
    #1; check("mispredict_wins", bus.f_pc, 64'h13);
    bus.M_cnd = 1'b1;
    #1; check("taken_no_redirect", bus.f_pc, 64'h80);

    // Ret
    bus.M_icode = 4'h0; bus.M_cnd = 1'b0; bus.W_valM = 64'h55;
    #1; check("ret_redirect", bus.f_pc, 64'h55);
    bus.W_icode = 4'h0;
    #1; check("no_redirect", bus.f_pc, 64'h2);

    // Stall
    bus.f_icode = 4'h6; bus.f_valP = 64'h20;
    tick(); check("load_20", bus.F_predPC, 64'h20);
    bus.F_stall = 1'b1; bus.f_valP = 64'h30;
    tick(); check("stall_hold", bus.F_predPC, 64'h20);
    bus.F_stall = 1'b0;
    tick(); check("stall_release", bus.F_predPC, 64'h30);
    reset = 1'b1; bus.F_stall = 1'b1;
    tick(); check("reset_beats_stall", bus.F_predPC, 64'h0);
    reset = 1'b0; bus.F_stall = 1'b0;

    // Randomized run against a reference model of the fetch rules
    model_f = 64'h0;
    for (int i = 0; i < 300; i++) begin
      reset       = ($urandom_range(0, 19) == 0);
      bus.F_stall = ($urandom_range(0, 3) == 0);
      bus.M_icode = rand_icode();
      bus.M_cnd   = 1'($urandom_range(0, 1));
      bus.M_valA  = {$urandom, $urandom};
      bus.W_icode = rand_icode();
      bus.W_valM  = {$urandom, $urandom};
      bus.f_icode = rand_icode();
      bus.f_valC  = {$urandom, $urandom};
      bus.f_valP  = {$urandom, $urandom};
      #1;
      exp_pred = (bus.f_icode == 4'h7 || bus.f_icode == 4'h8) ? bus.f_valC : bus.f_valP;
      if (bus.M_icode == 4'h7 && !bus.M_cnd) exp_pc = bus.M_valA;
      else if (bus.W_icode == 4'h9)          exp_pc = bus.W_valM;
      else                                   exp_pc = model_f;
      check("rand_f_predPC", bus.f_predPC, exp_pred);
      check("rand_f_pc", bus.f_pc, exp_pc);
      next_f = reset ? 64'h0 : (bus.F_stall ? model_f : exp_pred);
      tick();
      model_f = next_f;
      check("rand_F_predPC", bus.F_predPC, model_f);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
